// File: rtl/uram_stream_reader.sv
// Streams a (base, count) range out of a fixed-latency, non-stallable memory as valid/ready words.
// Optional stall_cycles counter is enabled by defining URAM_READER_STALL_CNT_EN.
module uram_stream_reader #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned ADDRESS_WIDTH = 12,
    parameter int unsigned READ_LATENCY  = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [ADDRESS_WIDTH:0]   count,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0]    mem_dout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_last
`ifdef URAM_READER_STALL_CNT_EN
    ,
    output logic [31:0]              stall_cycles
`endif
);

    localparam int unsigned FIFO_DEPTH = READ_LATENCY + 2;
    localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW       = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW:0] DepthW   = (CntW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [ADDRESS_WIDTH:0]   remaining_q, remaining_d;
    logic                     done_q, done_d;
    logic [READ_LATENCY-1:0]  vld_sr_q, vld_sr_d;
    logic [READ_LATENCY-1:0]  last_sr_q, last_sr_d;
    logic [CntW-1:0]          inflight_q, inflight_d;
    logic [CntW-1:0]          fifo_cnt_q, fifo_cnt_d;
    logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0]    fifo_data_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    fifo_data_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]    fifo_last_q, fifo_last_d;

    logic            issue, final_issue, push, pop, accept;
    logic [CntW:0]   credit_used;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Credit uses registered counts only, so out_ready never reaches mem_raddr combinationally.
    assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
    assign issue       = (state_q == StIssue) && (credit_used < DepthW);
    assign final_issue = (remaining_q == {{ADDRESS_WIDTH{1'b0}}, 1'b1});
    assign push        = vld_sr_q[READ_LATENCY-1];
    assign pop         = out_valid && out_ready;
    assign accept      = (state_q == StIdle) && start;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;

        vld_sr_d[0]  = issue;
        last_sr_d[0] = issue && final_issue;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_sr_d[i]  = vld_sr_q[i-1];
            last_sr_d[i] = last_sr_q[i-1];
        end

        inflight_d = inflight_q + CntW'(issue) - CntW'(push);
        fifo_cnt_d = fifo_cnt_q + CntW'(push) - CntW'(pop);

        if (push) begin
            fifo_data_d[wr_ptr_q] = mem_dout;
            fifo_last_d[wr_ptr_q] = last_sr_q[READ_LATENCY-1];
            wr_ptr_d              = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (count != '0) begin
                        state_d     = StIssue;
                        addr_d      = base_addr;
                        remaining_d = count;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StIssue: begin
                if (issue) begin
                    addr_d      = addr_q + ADDRESS_WIDTH'(1);
                    remaining_d = remaining_q - (ADDRESS_WIDTH + 1)'(1);
                    if (final_issue) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pop && out_last) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            done_q      <= 1'b0;
            vld_sr_q    <= '0;
            last_sr_q   <= '0;
            inflight_q  <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_data_q <= '{default: '0};
            fifo_last_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            vld_sr_q    <= vld_sr_d;
            last_sr_q   <= last_sr_d;
            inflight_q  <= inflight_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_data_q <= fifo_data_d;
            fifo_last_q <= fifo_last_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign mem_raddr = addr_q;
    assign out_valid = (fifo_cnt_q != '0);
    assign out_data  = fifo_data_q[rd_ptr_q];
    assign out_last  = out_valid && fifo_last_q[rd_ptr_q];

`ifdef URAM_READER_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (accept) begin
            stall_d = '0;
        end else if (busy && out_valid && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_uram_stream_reader.sv
// Scoreboard bench for uram_stream_reader with a latency-accurate memory model (mem[i] = i).
module tb_uram_stream_reader;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 12;
    localparam int unsigned RL = 2;
    localparam int unsigned FD = RL + 2;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_dout;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
`ifdef URAM_READER_STALL_CNT_EN
    logic [31:0]   stall_cycles;
`endif

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] exp_data[$];
    bit            exp_last[$];
    logic [AW-1:0] rpipe [RL];

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {{(DW-AW){1'b0}}, a};
    endfunction

    always #5 clock = ~clock;

    always @(posedge clock) begin
        rpipe[0] <= mem_raddr;
        for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_dout = mem_word(rpipe[RL-1]);

    uram_stream_reader #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .READ_LATENCY (RL)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .base_addr   (base_addr),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .mem_raddr   (mem_raddr),
        .mem_dout    (mem_dout),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last)
`ifdef URAM_READER_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    task automatic push_exp(input logic [AW-1:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            exp_data.push_back(mem_word(b + AW'(i)));
            exp_last.push_back(i == n - 1);
        end
    endtask

    // Leaves the caller at the falling edge of the first cycle after the start edge.
    task automatic start_req(input logic [AW-1:0] b, input logic [AW:0] c);
        @(negedge clock);
        start = 1'b1;
        base_addr = b;
        count = c;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        count = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({busy, done, out_valid, out_last} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=0000", {busy, done, out_valid, out_last});
        end
        checks++;
        if (out_data !== '0 || mem_raddr !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h want=0/0", out_data, mem_raddr);
        end
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got=%b%b want=00", busy, out_valid);
        end
    endtask

    task automatic test_basic();
        int cyc = 1, first_v = -1, last_c = -1, done_c = -1;
        logic [DW-1:0] ed;
        bit el;
        out_ready = 1'b1;
        push_exp(12'h010, 4);
        start_req(12'h010, 13'd4);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy_rise got=%b want=1", busy);
        end
        while (done_c < 0 && cyc <= 40) begin
            if (out_valid === 1'b1) begin
                if (first_v < 0) first_v = cyc;
                if (out_last === 1'b1) last_c = cyc;
                if (exp_data.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL basic_extra_word got=%h want=none", out_data);
                end else begin
                    ed = exp_data.pop_front();
                    el = exp_last.pop_front();
                    checks++;
                    if (out_data !== ed || out_last !== el) begin
                        failures++;
                        $display("FAIL basic_word got=%h/%b want=%h/%b", out_data, out_last, ed, el);
                    end
                end
            end
            if (done === 1'b1) done_c = cyc;
            else begin
                @(negedge clock);
                cyc++;
            end
        end
        checks++;
        if (first_v != 4) begin
            failures++;
            $display("FAIL basic_first_latency got=%0d want=4", first_v);
        end
        checks++;
        if (last_c != 7) begin
            failures++;
            $display("FAIL basic_last_cycle got=%0d want=7", last_c);
        end
        checks++;
        if (done_c != 8) begin
            failures++;
            $display("FAIL basic_done_cycle got=%0d want=8", done_c);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy_fall got=%b want=0", busy);
        end
        checks++;
        if (exp_data.size() != 0) begin
            failures++;
            $display("FAIL basic_missing got=%0d want=0", exp_data.size());
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_pulse got=%b want=0", done);
        end
    endtask

    task automatic test_wrap();
        int cyc = 1, done_c = -1;
        logic [DW-1:0] ed;
        bit el;
        out_ready = 1'b1;
        push_exp(12'hFFE, 4);
        start_req(12'hFFE, 13'd4);
        checks++;
        if (mem_raddr !== 12'hFFE) begin
            failures++;
            $display("FAIL wrap_first_raddr got=%h want=ffe", mem_raddr);
        end
        while (done_c < 0 && cyc <= 40) begin
            if (out_valid === 1'b1) begin
                if (exp_data.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL wrap_extra_word got=%h want=none", out_data);
                end else begin
                    ed = exp_data.pop_front();
                    el = exp_last.pop_front();
                    checks++;
                    if (out_data !== ed || out_last !== el) begin
                        failures++;
                        $display("FAIL wrap_word got=%h/%b want=%h/%b", out_data, out_last, ed, el);
                    end
                end
            end
            if (done === 1'b1) done_c = cyc;
            else begin
                @(negedge clock);
                cyc++;
            end
        end
        checks++;
        if (done_c < 0 || exp_data.size() != 0) begin
            failures++;
            $display("FAIL wrap_complete got=done%0d/left%0d want=done/0", done_c, exp_data.size());
        end
    endtask

    task automatic test_backpressure();
        int cyc = 1, done_c = -1, hs = 0, max_out = 0, outst;
        bit prev_stall = 0, prev_l = 0, el;
        logic [DW-1:0] prev_d = '0, ed;
        push_exp(12'h100, 16);
        start_req(12'h100, 13'd16);
        while (done_c < 0 && cyc <= 300) begin
            out_ready = (cyc % 4 == 1);
            outst = int'(12'(mem_raddr - 12'h100)) - hs;
            if (outst > max_out) max_out = outst;
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_d || out_last !== prev_l) begin
                    failures++;
                    $display("FAIL bp_stable got=%b/%h/%b want=1/%h/%b",
                             out_valid, out_data, out_last, prev_d, prev_l);
                end
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_d = out_data;
            prev_l = out_last;
            if (out_valid === 1'b1 && out_ready) begin
                hs++;
                if (exp_data.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL bp_extra_word got=%h want=none", out_data);
                end else begin
                    ed = exp_data.pop_front();
                    el = exp_last.pop_front();
                    checks++;
                    if (out_data !== ed || out_last !== el) begin
                        failures++;
                        $display("FAIL bp_word got=%h/%b want=%h/%b", out_data, out_last, ed, el);
                    end
                end
            end
            if (done === 1'b1) done_c = cyc;
            else begin
                @(negedge clock);
                cyc++;
            end
        end
        out_ready = 1'b1;
        checks++;
        if (hs != 16 || done_c < 0) begin
            failures++;
            $display("FAIL bp_count got=%0d/done%0d want=16/done", hs, done_c);
        end
        checks++;
        if (max_out > FD) begin
            failures++;
            $display("FAIL bp_outstanding got=%0d want<=%0d", max_out, FD);
        end
    endtask

    task automatic test_zero_len();
        bit seen_valid = 0;
        int extra_done = 0;
        start_req(12'h055, 13'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_done got=%b%b%b want=100", done, busy, out_valid);
        end
        repeat (5) begin
            @(negedge clock);
            if (out_valid === 1'b1) seen_valid = 1;
            if (done === 1'b1) extra_done++;
        end
        checks++;
        if (seen_valid || extra_done != 0) begin
            failures++;
            $display("FAIL zero_quiet got=valid%0b/done%0d want=0/0", seen_valid, extra_done);
        end
    endtask

    task automatic test_full_len();
        int cyc = 1, done_c = -1, nwords = 0, lasts = 0, last_idx = -1, errs = 0;
        logic [DW-1:0] ed;
        bit el;
        out_ready = 1'b1;
        push_exp(12'h123, 4096);
        start_req(12'h123, 13'h1000);
        while (done_c < 0 && cyc <= 4300) begin
            if (out_valid === 1'b1) begin
                nwords++;
                if (out_last === 1'b1) begin
                    lasts++;
                    last_idx = nwords;
                end
                if (exp_data.size() == 0) errs++;
                else begin
                    ed = exp_data.pop_front();
                    el = exp_last.pop_front();
                    if (out_data !== ed || out_last !== el) errs++;
                end
            end
            if (done === 1'b1) done_c = cyc;
            else begin
                @(negedge clock);
                cyc++;
            end
        end
        checks++;
        if (errs != 0) begin
            failures++;
            $display("FAIL full_words got=%0d_bad want=0_bad", errs);
        end
        checks++;
        if (nwords != 4096 || lasts != 1 || last_idx != 4096) begin
            failures++;
            $display("FAIL full_shape got=%0d/%0d/%0d want=4096/1/4096", nwords, lasts, last_idx);
        end
        checks++;
        if (done_c != 4100) begin
            failures++;
            $display("FAIL full_done_cycle got=%0d want=4100", done_c);
        end
    endtask

    task automatic test_ignored_start();
        int cyc = 1, done_c = -1, stray = 0;
        logic [DW-1:0] ed;
        bit el;
        out_ready = 1'b1;
        push_exp(12'h040, 6);
        start_req(12'h040, 13'd6);
        while (done_c < 0 && cyc <= 60) begin
            if (cyc == 2) begin
                start = 1'b1;
                base_addr = 12'h800;
                count = 13'd2;
            end else if (cyc == 3) start = 1'b0;
            if (out_valid === 1'b1) begin
                if (exp_data.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL ign_extra_word got=%h want=none", out_data);
                end else begin
                    ed = exp_data.pop_front();
                    el = exp_last.pop_front();
                    checks++;
                    if (out_data !== ed || out_last !== el) begin
                        failures++;
                        $display("FAIL ign_word got=%h/%b want=%h/%b", out_data, out_last, ed, el);
                    end
                end
            end
            if (done === 1'b1) done_c = cyc;
            else begin
                @(negedge clock);
                cyc++;
            end
        end
        repeat (6) begin
            @(negedge clock);
            if (out_valid === 1'b1 || busy === 1'b1 || done === 1'b1) stray++;
        end
        checks++;
        if (done_c < 0 || exp_data.size() != 0 || stray != 0) begin
            failures++;
            $display("FAIL ign_effect got=done%0d/left%0d/stray%0d want=done/0/0",
                     done_c, exp_data.size(), stray);
        end
    endtask

    task automatic test_reset_midop();
        int cyc = 1, hs = 0, done_c = -1, first_v = -1;
        logic [DW-1:0] ed;
        bit el;
        out_ready = 1'b1;
        push_exp(12'h200, 20);
        start_req(12'h200, 13'd20);
        while (hs < 5 && cyc <= 40) begin
            if (out_valid === 1'b1) begin
                hs++;
                ed = exp_data.pop_front();
                el = exp_last.pop_front();
                checks++;
                if (out_data !== ed || out_last !== el) begin
                    failures++;
                    $display("FAIL rst_pre_word got=%h/%b want=%h/%b", out_data, out_last, ed, el);
                end
            end
            @(negedge clock);
            cyc++;
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, out_valid, out_last} !== 4'b0000 || out_data !== '0 || mem_raddr !== '0) begin
            failures++;
            $display("FAIL rst_midop_clear got=%b/%h/%h want=0000/0/0",
                     {busy, done, out_valid, out_last}, out_data, mem_raddr);
        end
        exp_data.delete();
        exp_last.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        push_exp(12'h300, 3);
        start_req(12'h300, 13'd3);
        cyc = 1;
        while (done_c < 0 && cyc <= 40) begin
            if (out_valid === 1'b1) begin
                if (first_v < 0) first_v = cyc;
                if (exp_data.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rst_post_extra got=%h want=none", out_data);
                end else begin
                    ed = exp_data.pop_front();
                    el = exp_last.pop_front();
                    checks++;
                    if (out_data !== ed || out_last !== el) begin
                        failures++;
                        $display("FAIL rst_post_word got=%h/%b want=%h/%b", out_data, out_last, ed, el);
                    end
                end
            end
            if (done === 1'b1) done_c = cyc;
            else begin
                @(negedge clock);
                cyc++;
            end
        end
        checks++;
        if (first_v != 4 || done_c < 0 || exp_data.size() != 0) begin
            failures++;
            $display("FAIL rst_post_shape got=first%0d/done%0d/left%0d want=4/done/0",
                     first_v, done_c, exp_data.size());
        end
    endtask

`ifdef URAM_READER_STALL_CNT_EN
    task automatic test_stall_cnt();
        int cyc = 1, done_c = -1, forced = 0;
        logic [DW-1:0] ed;
        bit el;
        out_ready = 1'b0;
        push_exp(12'h060, 3);
        start_req(12'h060, 13'd3);
        while (done_c < 0 && cyc <= 60) begin
            if (out_valid === 1'b1) begin
                if (forced < 7) begin
                    out_ready = 1'b0;
                    forced++;
                end else out_ready = 1'b1;
            end else out_ready = 1'b0;
            if (out_valid === 1'b1 && out_ready) begin
                ed = exp_data.pop_front();
                el = exp_last.pop_front();
                checks++;
                if (out_data !== ed || out_last !== el) begin
                    failures++;
                    $display("FAIL stall_word got=%h/%b want=%h/%b", out_data, out_last, ed, el);
                end
            end
            if (done === 1'b1) done_c = cyc;
            else begin
                @(negedge clock);
                cyc++;
            end
        end
        checks++;
        if (stall_cycles !== 32'd7 || done_c < 0) begin
            failures++;
            $display("FAIL stall_count got=%0d/done%0d want=7/done", stall_cycles, done_c);
        end
        out_ready = 1'b1;
        start_req(12'h000, 13'd0);
        checks++;
        if (stall_cycles !== 32'd0) begin
            failures++;
            $display("FAIL stall_clear got=%0d want=0", stall_cycles);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_full_len();
        test_ignored_start();
        test_reset_midop();
`ifdef URAM_READER_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
